// File: rtl/ad_decimate_dump_pkg.sv
// Shared constants for the receive-side ADC decimator of the QPSK chain.
//   ADC_DW   : ADC sample width (two's complement)
//   DECIM    : decimation factor (power of two)
//   DECIM_W  : log2(DECIM), phase counter / accumulator growth width
//   mode_e   : per-group decimation mode (pick one sample or integrate-and-dump)
package ad_decimate_dump_pkg;

    localparam int ADC_DW  = 12;
    localparam int DECIM   = 4;
    localparam int DECIM_W = 2;

    typedef enum logic {
        MODE_PICK = 1'b0,
        MODE_SUM  = 1'b1
    } mode_e;

endpackage

// File: rtl/ad_decimate_dump_if.sv
// Sample/control bundle between the ADC capture registers, the decimator and
// the QPSK demapper.
//   in_ad_data0/1   : I/Q ADC samples, new sample every clock
//   sync_in         : current sample starts a new group
//   mode            : 0 = pick, 1 = integrate-and-dump
//   phase_sel       : pick phase
//   out_ad_data0/1  : decimated I/Q samples
//   out_valid       : 1-cycle strobe, out_ad_data* updated this cycle
//   grp_phase       : current position inside the group
// master = sample source / consumer side, slave = decimator.
interface ad_decimate_dump_if
    import ad_decimate_dump_pkg::*;
#(
    parameter int DW = ADC_DW,
    parameter int CW = DECIM_W
);
    logic signed [DW-1:0] in_ad_data0;
    logic signed [DW-1:0] in_ad_data1;
    logic                 sync_in;
    logic                 mode;
    logic [CW-1:0]        phase_sel;
    logic signed [DW-1:0] out_ad_data0;
    logic signed [DW-1:0] out_ad_data1;
    logic                 out_valid;
    logic [CW-1:0]        grp_phase;

    modport master (
        output in_ad_data0, in_ad_data1, sync_in, mode, phase_sel,
        input  out_ad_data0, out_ad_data1, out_valid, grp_phase
    );

    modport slave (
        input  in_ad_data0, in_ad_data1, sync_in, mode, phase_sel,
        output out_ad_data0, out_ad_data1, out_valid, grp_phase
    );

endinterface

// File: rtl/ad_decimate_dump_lane.sv
// One I or Q lane of the decimator: pick register, integrate-and-dump
// accumulator and the held output register.
//   clk_40M, rst : sample clock, async active-high reset
//   sample       : ADC sample of this cycle
//   first        : sample is position 0 of its group
//   last         : sample completes the group, output updates on this edge
//   pick_en      : sample is at the selected pick phase
//   mode_cur     : mode in force for the current group
//   dout         : decimated output, held between strobes
module ad_decimate_dump_lane
    import ad_decimate_dump_pkg::*;
#(
    parameter int DW = ADC_DW,
    parameter int CW = DECIM_W
) (
    input  logic                 clk_40M,
    input  logic                 rst,
    input  logic signed [DW-1:0] sample,
    input  logic                 first,
    input  logic                 last,
    input  logic                 pick_en,
    input  mode_e                mode_cur,
    output logic signed [DW-1:0] dout
);

    logic signed [DW+CW-1:0] acc_q, acc_d;
    logic signed [DW+CW-1:0] sample_ext;
    logic signed [DW+CW-1:0] acc_sum;
    logic signed [DW+CW-1:0] acc_shift;
    logic signed [DW-1:0]    pick_q, pick_d;
    logic signed [DW-1:0]    dout_q, dout_d;
    logic signed [DW-1:0]    pick_val;

    always_comb begin
        sample_ext = {{CW{sample[DW-1]}}, sample};
        acc_sum    = acc_q + sample_ext;
        acc_d      = first ? sample_ext : acc_sum;
        // Mean of the group; the arithmetic shift floors, and DECIM samples
        // of DW bits always fit in DW+CW bits, so the top bits are sign only.
        acc_shift  = acc_sum >>> CW;
        // A pick at the last phase must bypass the register to meet the
        // group-end output update.
        pick_val   = pick_en ? sample : pick_q;
        pick_d     = pick_val;
        dout_d     = dout_q;
        if (last) begin
            dout_d = (mode_cur == MODE_SUM) ? acc_shift[DW-1:0] : pick_val;
        end
    end

    always_ff @(posedge clk_40M or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            pick_q <= '0;
            dout_q <= '0;
        end else begin
            acc_q  <= acc_d;
            pick_q <= pick_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ad_decimate_dump.sv
// Receive-side I/Q decimator: reduces two ADC lanes by 2**CW to symbol rate,
// either picking one sample per group or integrating-and-dumping.
//   clk_40M : 40 MHz sample clock
//   rst     : async active-high reset; the first sample after release is
//             sample 0 of a new group
//   bus     : sample/control bundle (slave side)
module ad_decimate_dump
    import ad_decimate_dump_pkg::*;
#(
    parameter int DW = ADC_DW,
    parameter int CW = DECIM_W
) (
    input  logic                clk_40M,
    input  logic                rst,
    ad_decimate_dump_if.slave   bus
);

    localparam int NDEC = 1 << CW;

    logic [CW-1:0] cnt_q, cnt_d, cnt_cur;
    logic [CW-1:0] phase_q, phase_d, phase_cur;
    mode_e         mode_q, mode_d, mode_cur;
    logic          valid_q, valid_d;
    logic          first, last, pick_en;

    // sync_in forces the current sample to position 0; mode/phase are taken
    // straight from the inputs at position 0 so the first sample of a group
    // already sees the new settings, then held for the rest of the group.
    always_comb begin
        cnt_cur   = bus.sync_in ? '0 : cnt_q;
        first     = (cnt_cur == '0);
        last      = (cnt_cur == CW'(NDEC - 1));
        mode_cur  = first ? mode_e'(bus.mode) : mode_q;
        phase_cur = first ? bus.phase_sel : phase_q;
        pick_en   = (cnt_cur == phase_cur);
        cnt_d     = cnt_cur + CW'(1);
        mode_d    = mode_cur;
        phase_d   = phase_cur;
        valid_d   = last;
    end

    always_ff @(posedge clk_40M or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= '0;
            mode_q  <= MODE_PICK;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grp_phase = cnt_cur;
    assign bus.out_valid = valid_q;

    ad_decimate_dump_lane #(.DW(DW), .CW(CW)) u_lane0 (
        .clk_40M  (clk_40M),
        .rst      (rst),
        .sample   (bus.in_ad_data0),
        .first    (first),
        .last     (last),
        .pick_en  (pick_en),
        .mode_cur (mode_cur),
        .dout     (bus.out_ad_data0)
    );

    ad_decimate_dump_lane #(.DW(DW), .CW(CW)) u_lane1 (
        .clk_40M  (clk_40M),
        .rst      (rst),
        .sample   (bus.in_ad_data1),
        .first    (first),
        .last     (last),
        .pick_en  (pick_en),
        .mode_cur (mode_cur),
        .dout     (bus.out_ad_data1)
    );

endmodule

// File: tb/tb_ad_decimate_dump.sv
// Bench for ad_decimate_dump: directed vector table, hand-written sync and
// async-reset sequences, then randomized traffic against a group-level model.
module tb_ad_decimate_dump;
    import ad_decimate_dump_pkg::*;

    localparam int DW = ADC_DW;
    localparam int CW = DECIM_W;
    localparam int ND = 1 << CW;

    logic clk_40M = 1'b0;
    logic rst     = 1'b0;
    always #5 clk_40M = ~clk_40M;

    ad_decimate_dump_if #(.DW(DW), .CW(CW)) bus ();

    ad_decimate_dump #(.DW(DW), .CW(CW)) dut (
        .clk_40M (clk_40M),
        .rst     (rst),
        .bus     (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Model: samples of the open group, settings latched at its start,
    // expected outputs after the current edge.
    int q0[$];
    int q1[$];
    bit m_mode;
    int m_phase;
    bit e_valid;
    int e_o0, e_o1;

    typedef struct {
        int d0; int d1; bit sync; bit mode; int ph;
        bit ev; int eo0; int eo1;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int floor_div(input int s);
        if (s >= 0) return s / ND;
        return -((-s + ND - 1) / ND);
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_mode  = 1'b0;
        m_phase = 0;
        e_valid = 1'b0;
        e_o0    = 0;
        e_o1    = 0;
    endtask

    // Called just after a rising edge: presents one sample, checks grp_phase,
    // then checks the outputs just after the next rising edge.
    task automatic step(input int d0, input int d1, input bit sync, input bit mode, input int ph);
        int gp, s0, s1;
        bus.in_ad_data0 = DW'(d0);
        bus.in_ad_data1 = DW'(d1);
        bus.sync_in     = sync;
        bus.mode        = mode;
        bus.phase_sel   = CW'(ph);
        if (sync) begin
            q0.delete();
            q1.delete();
        end
        gp = q0.size();
        if (gp == 0) begin
            m_mode  = mode;
            m_phase = ph;
        end
        q0.push_back(d0);
        q1.push_back(d1);
        e_valid = 1'b0;
        if (q0.size() == ND) begin
            e_valid = 1'b1;
            if (m_mode) begin
                s0 = 0;
                s1 = 0;
                foreach (q0[k]) begin
                    s0 += q0[k];
                    s1 += q1[k];
                end
                e_o0 = floor_div(s0);
                e_o1 = floor_div(s1);
            end else begin
                e_o0 = q0[m_phase];
                e_o1 = q1[m_phase];
            end
            q0.delete();
            q1.delete();
        end
        #1;
        chk("grp_phase", int'(bus.grp_phase), gp);
        @(posedge clk_40M);
        #1;
        chk("out_valid", int'(bus.out_valid), int'(e_valid));
        chk("out0", int'(bus.out_ad_data0), e_o0);
        chk("out1", int'(bus.out_ad_data1), e_o1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_v;
        int nvalid;

        tbl[0]  = '{100, -2048, 1'b1, 1'b1, 0, 1'b0, 5, -7};
        tbl[1]  = '{200, -2048, 1'b0, 1'b1, 0, 1'b0, 5, -7};
        tbl[2]  = '{300, -2048, 1'b0, 1'b1, 0, 1'b0, 5, -7};
        tbl[3]  = '{400, -2048, 1'b0, 1'b1, 0, 1'b1, 250, -2048};
        tbl[4]  = '{-1,  2047,  1'b0, 1'b1, 0, 1'b0, 250, -2048};
        tbl[5]  = '{0,   2047,  1'b0, 1'b1, 0, 1'b0, 250, -2048};
        tbl[6]  = '{0,   2047,  1'b0, 1'b1, 0, 1'b0, 250, -2048};
        tbl[7]  = '{0,   2047,  1'b0, 1'b1, 0, 1'b1, -1, 2047};
        tbl[8]  = '{10,  20,    1'b0, 1'b0, 2, 1'b0, -1, 2047};
        tbl[9]  = '{11,  21,    1'b0, 1'b0, 2, 1'b0, -1, 2047};
        tbl[10] = '{12,  22,    1'b0, 1'b0, 2, 1'b0, -1, 2047};
        tbl[11] = '{13,  23,    1'b0, 1'b0, 2, 1'b1, 12, 22};
        tbl[12] = '{14,  24,    1'b0, 1'b0, 2, 1'b0, 12, 22};
        tbl[13] = '{15,  25,    1'b0, 1'b0, 3, 1'b0, 12, 22};
        tbl[14] = '{16,  26,    1'b0, 1'b0, 3, 1'b0, 12, 22};
        tbl[15] = '{17,  27,    1'b0, 1'b0, 3, 1'b1, 16, 26};
        tbl[16] = '{18,  28,    1'b0, 1'b0, 3, 1'b0, 16, 26};
        tbl[17] = '{19,  29,    1'b0, 1'b0, 3, 1'b0, 16, 26};
        tbl[18] = '{20,  30,    1'b0, 1'b0, 3, 1'b0, 16, 26};
        tbl[19] = '{21,  31,    1'b0, 1'b0, 3, 1'b1, 21, 31};

        // Reset with non-zero inputs.
        bus.in_ad_data0 = DW'(5);
        bus.in_ad_data1 = DW'(-7);
        bus.sync_in     = 1'b0;
        bus.mode        = 1'b1;
        bus.phase_sel   = CW'(0);
        #1 rst = 1'b1;
        @(posedge clk_40M);
        @(posedge clk_40M);
        #1;
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_out0", int'(bus.out_ad_data0), 0);
        chk("rst_out1", int'(bus.out_ad_data1), 0);
        chk("rst_grp_phase", int'(bus.grp_phase), 0);
        rst = 1'b0;
        model_reset();
        first_v = -1;
        for (int i = 0; i < 8; i++) begin
            step(5, -7, 1'b0, 1'b1, 0);
            if (bus.out_valid === 1'b1 && first_v < 0) first_v = i;
        end
        chk("first_valid_cycle", first_v, ND - 1);

        // Directed table: sum, rounding, pick with mid-group phase change.
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].d0, tbl[i].d1, tbl[i].sync, tbl[i].mode, tbl[i].ph);
            chk("tbl_valid", int'(bus.out_valid), int'(tbl[i].ev));
            chk("tbl_out0", int'(bus.out_ad_data0), tbl[i].eo0);
            chk("tbl_out1", int'(bus.out_ad_data1), tbl[i].eo1);
        end

        // Sync at cnt=2: group discarded, next valid ND cycles after the sync.
        nvalid = 0;
        step(1, 2, 1'b0, 1'b1, 0);
        nvalid += int'(bus.out_valid);
        step(3, 4, 1'b0, 1'b1, 0);
        nvalid += int'(bus.out_valid);
        step(50, 60, 1'b1, 1'b1, 0);
        nvalid += int'(bus.out_valid);
        for (int i = 0; i < ND - 2; i++) begin
            step(50, 60, 1'b0, 1'b1, 0);
            nvalid += int'(bus.out_valid);
        end
        chk("sync2_no_valid", nvalid, 0);
        step(50, 60, 1'b0, 1'b1, 0);
        chk("sync2_valid_after", int'(bus.out_valid), 1);
        chk("sync2_out0", int'(bus.out_ad_data0), 50);

        // Sync at cnt=3 (coincides with group end): no valid for that group.
        nvalid = 0;
        for (int i = 0; i < ND - 1; i++) begin
            step(-30, 30, 1'b0, 1'b0, 1);
            nvalid += int'(bus.out_valid);
        end
        step(7, 8, 1'b1, 1'b0, 1);
        nvalid += int'(bus.out_valid);
        chk("sync3_no_valid", nvalid, 0);
        for (int i = 0; i < ND - 1; i++) step(9, 10, 1'b0, 1'b0, 1);
        chk("sync3_pick_out0", int'(bus.out_ad_data0), 9);

        // Async reset mid-group at cnt=2.
        step(111, 222, 1'b0, 1'b1, 0);
        step(111, 222, 1'b0, 1'b1, 0);
        bus.in_ad_data0 = DW'(111);
        bus.in_ad_data1 = DW'(222);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", int'(bus.out_valid), 0);
        chk("arst_out0", int'(bus.out_ad_data0), 0);
        chk("arst_out1", int'(bus.out_ad_data1), 0);
        chk("arst_grp_phase", int'(bus.grp_phase), 0);
        model_reset();
        @(posedge clk_40M);
        #1 rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < ND - 1; i++) begin
            step(-8, 8, 1'b0, 1'b1, 0);
            nvalid += int'(bus.out_valid);
        end
        chk("arst_no_partial", nvalid, 0);
        step(-8, 8, 1'b0, 1'b1, 0);
        chk("arst_valid_after", int'(bus.out_valid), 1);
        chk("arst_out0_after", int'(bus.out_ad_data0), -8);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 4095)) - 2048,
                 ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, ND - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
